// File: rtl/mix_seq_pkg.sv
// mix_seq_pkg: shared phase encoding and mixing constants for mix_round_sequencer.
// Configuration macro: MIX_XSH_PHASE_EN (adds the XSH phase; 4 phases instead of 3).
package mix_seq_pkg;

    localparam int unsigned NUM_WORDS = 8;

`ifdef MIX_XSH_PHASE_EN
    localparam int unsigned NUM_PHASES = 4;
`else
    localparam int unsigned NUM_PHASES = 3;
`endif

    // Active phases are numbered 1..NUM_PHASES in execution order, so the
    // successor of any non-final phase is simply the next encoding.
    typedef enum logic [2:0] {
        IDLE,
        ADDK,
        CHAIN,
`ifdef MIX_XSH_PHASE_EN
        XSH,
`endif
        MULK
    } phase_t;

    localparam phase_t LAST_PHASE = phase_t'(NUM_PHASES);

    localparam int unsigned MUL_K [NUM_WORDS] = '{2, 3, 5, 7, 11, 13, 17, 19};
    localparam int unsigned ADD_K [NUM_WORDS] = '{3, 5, 7, 11, 13, 17, 19, 23};

endpackage

// File: rtl/mix_word_alu.sv
// mix_word_alu: combinational single-word mixing ALU.
// Given the phase, word index, current word and its neighbour, returns the new word.
// Configuration macro: MIX_XSH_PHASE_EN (enables the XSH operation).
module mix_word_alu
    import mix_seq_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  phase_t              phase,
    input  logic [2:0]          idx,
    input  logic [WORD_W-1:0]   s_i,
    input  logic [WORD_W-1:0]   s_nbr,
    output logic [WORD_W-1:0]   s_new
);

    // Per-phase word update, all arithmetic wrapping at WORD_W bits.
    always_comb begin
        s_new = s_i;
        case (phase)
            ADDK:    s_new = s_i + WORD_W'(idx);
            CHAIN:   s_new = s_i + s_nbr;
`ifdef MIX_XSH_PHASE_EN
            XSH:     s_new = s_i ^ (s_nbr << 16);
`endif
            MULK:    s_new = (s_i * WORD_W'(MUL_K[idx])) + WORD_W'(ADD_K[idx]);
            default: s_new = s_i;
        endcase
    end

endmodule

// File: rtl/mix_round_sequencer.sv
// mix_round_sequencer: 8-word mixing state driven through fixed phases by one
// shared word ALU, one word per cycle, for NUM_ROUNDS rounds per start.
// Configuration macro: MIX_XSH_PHASE_EN (inserts the XSH phase between CHAIN and MULK).
module mix_round_sequencer
    import mix_seq_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 4,
    parameter int unsigned WORD_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [2:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [7:0]        round_o
);

    phase_t            state;
    phase_t            state_n;
    logic [2:0]        idx;
    logic [7:0]        round;
    logic [WORD_W-1:0] s [NUM_WORDS];
    logic [2:0]        nbr_idx;
    logic [WORD_W-1:0] s_new;
    logic              last_word;
    logic              final_word;

    assign busy       = (state != IDLE);
    assign last_word  = (idx == 3'd7);
    assign final_word = (state == LAST_PHASE) && last_word && (round == 8'(NUM_ROUNDS - 1));
    assign rd_data    = s[rd_addr];
    assign round_o    = round;

`ifdef MIX_XSH_PHASE_EN
    assign nbr_idx = (state == XSH) ? (idx + 3'd3) : (idx + 3'd7);
`else
    assign nbr_idx = idx + 3'd7;
`endif

    mix_word_alu #(
        .WORD_W (WORD_W)
    ) u_alu (
        .phase (state),
        .idx   (idx),
        .s_i   (s[idx]),
        .s_nbr (s[nbr_idx]),
        .s_new (s_new)
    );

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next phase: advance after word 7; after the last phase loop or finish.
    always_comb begin
        state_n = state;
        if (state == IDLE) begin
            if (start) begin
                state_n = ADDK;
            end
        end else if (last_word) begin
            if (state != LAST_PHASE) begin
                state_n = phase_t'(state + 3'd1);
            end else if (final_word) begin
                state_n = IDLE;
            end else begin
                state_n = ADDK;
            end
        end
    end

    // State words, word/round counters and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                s[i] <= WORD_W'(i);
            end
            idx   <= '0;
            round <= '0;
            done  <= 1'b0;
        end else begin
            done <= final_word;
            if (state == IDLE) begin
                if (wr_en) begin
                    s[wr_addr] <= wr_data;
                end
                if (start) begin
                    idx   <= '0;
                    round <= '0;
                end
            end else begin
                s[idx] <= s_new;
                idx    <= idx + 3'd1;
                if ((state == LAST_PHASE) && last_word && !final_word) begin
                    round <= round + 8'd1;
                end
            end
        end
    end

endmodule
